// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin share of one single-word Avalon read master and one single-word
//   write master among NUM_REQ requesters. An accepted command becomes exactly one
//   BYTEENABLEWIDTH-byte read or write. Completion returns as a one-cycle pulse on
//   rsp_valid[id] with registered rsp_rdata/rsp_error.
// Ports
//   clk, reset            clock, async active-high reset
//   req_valid/write/addr/wdata   per-requester command (addr/wdata packed, req i at [i*W +: W])
//   req_ready             one-hot accept, combinational while idle
//   rsp_valid/rdata/error one-hot completion pulse, read data (0 for writes), error
//   busy                  transfer in flight
//   read_control_*, read_user_*     read master control/user interface
//   write_control_*, write_user_*   write master control/user interface
module mem_port_arbiter #(
  parameter int ADDRESSWIDTH    = 28,
  parameter int DATAWIDTH       = 32,
  parameter int BYTEENABLEWIDTH = 4,
  parameter int NUM_REQ         = 2,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*ADDRESSWIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATAWIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATAWIDTH-1:0]            rsp_rdata,
  output logic                            rsp_error,
  output logic                            busy,
  output logic                            read_control_go,
  output logic [ADDRESSWIDTH-1:0]         read_control_read_base,
  output logic [ADDRESSWIDTH-1:0]         read_control_read_length,
  output logic                            read_control_fixed_location,
  output logic                            read_user_read_buffer,
  input  logic                            read_control_done,
  input  logic [DATAWIDTH-1:0]            read_user_buffer_output_data,
  input  logic                            read_user_data_available,
  output logic                            write_control_go,
  output logic [ADDRESSWIDTH-1:0]         write_control_write_base,
  output logic [ADDRESSWIDTH-1:0]         write_control_write_length,
  output logic                            write_control_fixed_location,
  output logic                            write_user_write_buffer,
  output logic [DATAWIDTH-1:0]            write_user_buffer_data,
  input  logic                            write_control_done,
  input  logic                            write_user_buffer_full
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [3:0] {
    IDLE, RD_GO, RD_SETTLE, RD_WAIT, RD_ACK, WR_GO, WR_SETTLE, WR_WAIT, RSP
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [IW-1:0]           cmd_id_q, cmd_id_d;
  logic                    cmd_write_q, cmd_write_d;
  logic [ADDRESSWIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATAWIDTH-1:0]    cmd_wdata_q, cmd_wdata_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATAWIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_error_q, rsp_error_d;

  logic                    found;
  logic [IW-1:0]           grant_id;
  logic [NUM_REQ-1:0]      grant;
  logic                    timeout;
  logic                    fin;
  logic [DATAWIDTH-1:0]    fin_data;
  logic                    fin_err;

  // Requester index ptr+k, wrapped into [0, NUM_REQ).
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  // Search starts just past the last winner, so the last winner ranks lowest.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid[rr_idx(ptr_q, k)]) begin
        found    = 1'b1;
        grant_id = rr_idx(ptr_q, k);
      end
    end
    grant           = '0;
    grant[grant_id] = found;
  end

  assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cmd_id_d    = cmd_id_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cnt_d       = cnt_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    fin         = 1'b0;
    fin_data    = '0;
    fin_err     = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        ptr_d       = grant_id;
        cmd_id_d    = grant_id;
        cmd_write_d = req_write[grant_id];
        cmd_addr_d  = req_addr[int'(grant_id)*ADDRESSWIDTH +: ADDRESSWIDTH];
        cmd_wdata_d = req_wdata[int'(grant_id)*DATAWIDTH +: DATAWIDTH];
        cnt_d       = '0;
        state_d     = req_write[grant_id] ? WR_GO : RD_GO;
      end
      RD_GO: state_d = RD_SETTLE;
      // done may still be high from the previous transfer here, so it is not looked at.
      RD_SETTLE: begin
        state_d = RD_WAIT;
        cnt_d   = '0;
      end
      RD_WAIT: begin
        if (read_control_done)  state_d = RD_ACK;
        else if (timeout) begin fin = 1'b1; fin_err = 1'b1; end
        else                    cnt_d = cnt_q + 1'b1;
      end
      // Done without data in the FIFO is reported as an error rather than popping empty.
      RD_ACK: begin
        fin = 1'b1;
        if (read_user_data_available) fin_data = read_user_buffer_output_data;
        else                          fin_err  = 1'b1;
      end
      // Stalling on a full buffer counts toward the timeout.
      WR_GO: begin
        if (!write_user_buffer_full) state_d = WR_SETTLE;
        else if (timeout) begin fin = 1'b1; fin_err = 1'b1; end
        else                         cnt_d = cnt_q + 1'b1;
      end
      WR_SETTLE: begin
        state_d = WR_WAIT;
        cnt_d   = '0;
      end
      WR_WAIT: begin
        if (write_control_done) fin = 1'b1;
        else if (timeout) begin fin = 1'b1; fin_err = 1'b1; end
        else                    cnt_d = cnt_q + 1'b1;
      end
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (fin) begin
      state_d               = RSP;
      rsp_valid_d[cmd_id_q] = 1'b1;
      rsp_rdata_d           = fin_data;
      rsp_error_d           = fin_err;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= IW'(NUM_REQ - 1);
      cmd_id_q    <= '0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cmd_id_q    <= cmd_id_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign req_ready = (state_q == IDLE && !reset) ? grant : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign busy      = (state_q != IDLE);

  // Word-aligned base: the low two address bits are dropped.
  assign read_control_go              = (state_q == RD_GO);
  assign read_control_read_base       = cmd_addr_q & ~ADDRESSWIDTH'(3);
  assign read_control_read_length     = ADDRESSWIDTH'(BYTEENABLEWIDTH);
  assign read_control_fixed_location  = 1'b1;
  assign read_user_read_buffer        = (state_q == RD_ACK) && read_user_data_available;

  assign write_control_go             = (state_q == WR_GO) && !write_user_buffer_full && cmd_write_q;
  assign write_control_write_base     = cmd_addr_q & ~ADDRESSWIDTH'(3);
  assign write_control_write_length   = ADDRESSWIDTH'(BYTEENABLEWIDTH);
  assign write_control_fixed_location = 1'b1;
  assign write_user_write_buffer      = (state_q == WR_GO) && !write_user_buffer_full && cmd_write_q;
  assign write_user_buffer_data       = cmd_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (2 requesters, TIMEOUT_CYCLES=8).
// A negedge process models both Avalon masters (done two cycles after go) and
// logs accepts, go pulses, pops and responses for the checks.
module tb_mem_port_arbiter;
  localparam int AW = 28;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0]    req_valid = '0, req_write = '0, req_ready, rsp_valid;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [DW-1:0] rsp_rdata, mem_data = '0, wbuf_data;
  logic          rsp_error, busy;
  logic          rd_go, rd_fixed, rd_pop, rd_done = 1'b0, avail = 1'b0;
  logic [AW-1:0] rd_base_o, rd_len, wr_base_o, wr_len;
  logic          wr_go, wr_fixed, wr_buf, wr_done = 1'b0, full = 1'b0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .BYTEENABLEWIDTH(4),
                     .NUM_REQ(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .busy(busy),
    .read_control_go(rd_go), .read_control_read_base(rd_base_o),
    .read_control_read_length(rd_len), .read_control_fixed_location(rd_fixed),
    .read_user_read_buffer(rd_pop), .read_control_done(rd_done),
    .read_user_buffer_output_data(mem_data), .read_user_data_available(avail),
    .write_control_go(wr_go), .write_control_write_base(wr_base_o),
    .write_control_write_length(wr_len), .write_control_fixed_location(wr_fixed),
    .write_user_write_buffer(wr_buf), .write_user_buffer_data(wbuf_data),
    .write_control_done(wr_done), .write_user_buffer_full(full)
  );

  typedef struct {
    int id; bit wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [DW-1:0] mem;
    bit avail; bit done; logic [AW-1:0] exp_base; logic [DW-1:0] exp_rdata;
    bit exp_err; int exp_lat; int exp_pop;
  } vec_t;
  typedef struct { int id; logic [DW-1:0] rdata; logic err; int cyc; } rsp_t;

  int n_tests = 0, n_fail = 0, cyc = 0;
  bit done_en = 1'b1;
  int acc_q[$], acc_cyc_q[$];
  rsp_t rsp_q[$];
  rsp_t mon_r;
  int rd_go_cnt, wr_go_cnt, wbuf_cnt, pop_cnt, shape_bad, dbl_cnt, wr_go_cyc;
  logic [AW-1:0] rd_base, wr_base;
  logic [DW-1:0] wr_data;
  int rd_ph = 0, wr_ph = 0;

  function automatic logic [1:0] oh(input int i);
    logic [1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic int oh2id(input logic [1:0] v);
    return v[1] ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    acc_q.delete(); acc_cyc_q.delete(); rsp_q.delete();
    rd_go_cnt = 0; wr_go_cnt = 0; wbuf_cnt = 0; pop_cnt = 0; shape_bad = 0; dbl_cnt = 0;
    wr_go_cyc = 0; rd_base = '0; wr_base = '0; wr_data = '0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Bus monitor plus master model.
  initial forever begin
    @(negedge clk);
    if (req_ready != 2'b00) begin acc_q.push_back(oh2id(req_ready)); acc_cyc_q.push_back(cyc); end
    if ($countones(req_ready) > 1) dbl_cnt++;
    if (rd_go) begin
      rd_go_cnt++; rd_base = rd_base_o;
      if (rd_len != 28'd4 || !rd_fixed) shape_bad++;
    end
    if (wr_go) begin
      wr_go_cnt++; wr_go_cyc = cyc; wr_base = wr_base_o; wr_data = wbuf_data;
      if (wr_len != 28'd4 || !wr_fixed) shape_bad++;
    end
    if (wr_buf) wbuf_cnt++;
    if (rd_pop) pop_cnt++;
    if (rsp_valid != 2'b00) begin
      mon_r.id = oh2id(rsp_valid); mon_r.rdata = rsp_rdata; mon_r.err = rsp_error; mon_r.cyc = cyc;
      rsp_q.push_back(mon_r);
      if ($countones(rsp_valid) > 1) dbl_cnt++;
    end
    rd_done = 1'b0;
    wr_done = 1'b0;
    if (reset) begin
      rd_ph = 0; wr_ph = 0;
    end else begin
      // go cycle = phase 1, settle = 2, first wait cycle = 3 -> done there.
      if (rd_go) rd_ph = 1; else if (rd_ph != 0) rd_ph++;
      if (rd_ph == 3) begin rd_done = done_en; rd_ph = 0; end
      if (wr_go) wr_ph = 1; else if (wr_ph != 0) wr_ph++;
      if (wr_ph == 3) begin wr_done = done_en; wr_ph = 0; end
    end
  end

  task automatic run_vec(input vec_t v, input int k);
    int n;
    string s;
    s = $sformatf("v%0d", k);
    @(posedge clk); #1;
    clear_mon();
    avail = v.avail; mem_data = v.mem; done_en = v.done;
    req_addr = '0; req_wdata = '0; req_write = '0;
    req_addr[v.id*AW +: AW] = v.addr;
    req_wdata[v.id*DW +: DW] = v.wdata;
    req_write[v.id] = v.wr;
    req_valid = oh(v.id);
    #1 chk({s, "_ready"}, req_ready, oh(v.id));
    @(posedge clk); #1;
    req_valid = '0;
    n = 0;
    while (rsp_q.size() == 0 && n < 30) begin @(negedge clk); #1; n++; end
    chk({s, "_accepts"}, acc_q.size(), 1);
    if (rsp_q.size() == 0 || acc_q.size() == 0) begin
      chk({s, "_rsp_seen"}, 0, 1);
    end else begin
      chk({s, "_rsp_id"}, rsp_q[0].id, v.id);
      chk({s, "_rdata"}, rsp_q[0].rdata, v.exp_rdata);
      chk({s, "_err"}, rsp_q[0].err, v.exp_err);
      chk({s, "_latency"}, rsp_q[0].cyc - acc_cyc_q[0], v.exp_lat);
    end
    chk({s, "_rd_go"}, rd_go_cnt, v.wr ? 0 : 1);
    chk({s, "_wr_go"}, wr_go_cnt, v.wr ? 1 : 0);
    chk({s, "_base"}, v.wr ? wr_base : rd_base, v.exp_base);
    chk({s, "_pop"}, pop_cnt, v.exp_pop);
    chk({s, "_len_fixed"}, shape_bad, 0);
    if (v.wr) chk({s, "_wdata"}, wr_data, v.wdata);
  endtask

  vec_t vecs[8];

  initial begin
    int n;
    vecs[0] = '{0, 1'b0, 28'h8000000, 32'h0,        32'hAAAA0000, 1'b1, 1'b1, 28'h8000000, 32'hAAAA0000, 1'b0, 5, 1};
    vecs[1] = '{1, 1'b1, 28'h8000090, 32'h12345678, 32'h0,        1'b1, 1'b1, 28'h8000090, 32'h0,        1'b0, 4, 0};
    vecs[2] = '{0, 1'b0, 28'h8000006, 32'h0,        32'h5A5A1234, 1'b1, 1'b1, 28'h8000004, 32'h5A5A1234, 1'b0, 5, 1};
    vecs[3] = '{1, 1'b0, 28'h800000B, 32'h0,        32'hDEADBEEF, 1'b1, 1'b1, 28'h8000008, 32'hDEADBEEF, 1'b0, 5, 1};
    vecs[4] = '{0, 1'b1, 28'h0000003, 32'hCAFEF00D, 32'h0,        1'b1, 1'b1, 28'h0000000, 32'h0,        1'b0, 4, 0};
    vecs[5] = '{1, 1'b0, 28'h800000C, 32'h0,        32'h11111111, 1'b0, 1'b1, 28'h800000C, 32'h0,        1'b1, 5, 0};
    // done never returns: 8 wait cycles then an error response
    vecs[6] = '{0, 1'b0, 28'h8000100, 32'h0,        32'h22222222, 1'b1, 1'b0, 28'h8000100, 32'h0,        1'b1, 11, 0};
    vecs[7] = '{1, 1'b1, 28'h8000204, 32'h87654321, 32'h0,        1'b1, 1'b0, 28'h8000204, 32'h0,        1'b1, 11, 0};
    clear_mon();

    // Reset state, with both requesters already asking.
    repeat (2) @(posedge clk);
    #1 req_valid = 2'b11;
    #1;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rd_go", rd_go, 1'b0);
    chk("rst_wr_go", wr_go, 1'b0);
    chk("rst_wr_buf", wr_buf, 1'b0);
    chk("rst_rd_pop", rd_pop, 1'b0);
    reset = 1'b0;
    #1 chk("rst_first_grant", req_ready, 2'b01);
    req_valid = 2'b00;

    for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

    // Write stalled by a full buffer for three cycles.
    @(posedge clk); #1;
    clear_mon();
    done_en = 1'b1; full = 1'b1;
    req_addr = '0; req_wdata = '0;
    req_addr[AW +: AW] = 28'h8000090;
    req_wdata[DW +: DW] = 32'h12345678;
    req_write = 2'b10; req_valid = 2'b10;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1 full = 1'b0;
    n = 0;
    while (rsp_q.size() == 0 && n < 30) begin @(negedge clk); #1; n++; end
    if (rsp_q.size() == 0 || acc_q.size() == 0) chk("stall_rsp_seen", 0, 1);
    else begin
      chk("stall_latency", rsp_q[0].cyc - acc_cyc_q[0], 7);
      chk("stall_go_delay", wr_go_cyc - acc_cyc_q[0], 4);
      chk("stall_rsp_id", rsp_q[0].id, 1);
      chk("stall_err", rsp_q[0].err, 1'b0);
    end
    chk("stall_go_cycles", wr_go_cnt, 1);
    chk("stall_wbuf_cycles", wbuf_cnt, 1);
    chk("stall_wdata", wr_data, 32'h12345678);

    // Reset while waiting for a read to complete.
    @(posedge clk); #1;
    clear_mon();
    done_en = 1'b0;
    req_addr = '0; req_write = '0;
    req_addr[0 +: AW] = 28'h8000010;
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 chk("midrst_busy_before", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_rd_go", rd_go, 1'b0);
    chk("midrst_rsp_valid", rsp_valid, 2'b00);
    @(posedge clk); #1;
    reset = 1'b0;
    done_en = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("midrst_no_rsp", rsp_q.size(), 0);

    // Round robin with both requesters held valid; req0 favoured after reset.
    clear_mon();
    req_addr = '0; req_wdata = '0;
    req_addr[0 +: AW] = 28'h8000020;
    req_addr[AW +: AW] = 28'h8000040;
    req_wdata[DW +: DW] = 32'h0BADF00D;
    req_write = 2'b10; avail = 1'b1; mem_data = 32'h600DCAFE;
    req_valid = 2'b11;
    #1 chk("rr_first_after_rst", req_ready, 2'b01);
    n = 0;
    while (acc_q.size() < 4 && n < 80) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = '0;
    n = 0;
    while (rsp_q.size() < 4 && n < 40) begin @(negedge clk); #1; n++; end
    chk("rr_accepts", acc_q.size(), 4);
    chk("rr_rsps", rsp_q.size(), 4);
    chk("rr_double_grant", dbl_cnt, 0);
    for (int k = 0; k < 4; k++) begin
      if (k < acc_q.size()) chk($sformatf("rr_grant%0d", k), acc_q[k], k % 2);
      if (k < rsp_q.size()) chk($sformatf("rr_rsp%0d", k), rsp_q[k].id, k % 2);
    end
    chk("rr_rd_go", rd_go_cnt, 2);
    chk("rr_wr_go", wr_go_cnt, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
